// File: rtl/rv32e_gpio_pkg.sv
// rv32e_gpio_pkg: register map constants shared by the GPIO peripheral
package rv32e_gpio_pkg;
  localparam int PORT_STRIDE = 16;
  typedef enum logic [3:0] {
    OFF_DOUT = 4'h0,
    OFF_DIN  = 4'h4,
    OFF_STAT = 4'h8,
    OFF_MASK = 4'hC
  } reg_off_e;
endpackage

// File: rtl/rv32e_gpio_sync.sv
// rv32e_gpio_sync: multi-stage input synchroniser with rising-edge pulse output
module rv32e_gpio_sync
  import rv32e_gpio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] stg;
  logic [WIDTH-1:0] prev;
  always_ff @(posedge clk)
    if (reset) begin
      stg  <= '0;
      prev <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) stg[i] <= stg[i-1];
      prev <= stg[SYNC_STAGES-1];
    end
  assign q    = stg[SYNC_STAGES-1];
  assign rise = q & ~prev;
endmodule

// File: rtl/rv32e_mmio_gpio.sv
// rv32e_mmio_gpio: memory-mapped multi-port GPIO with sticky edge status; RV32E_GPIO_IRQ_EN adds IRQ_MASK and irq
module rv32e_mmio_gpio
  import rv32e_gpio_pkg::*;
#(
  parameter int NPORTS      = 4,
  parameter int WIDTH       = 8,
  parameter int ADDR_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sel,
  input  logic [ADDR_W-1:0]       addr_bus,
  input  logic [31:0]             write_data,
  input  logic                    write_sig,
  output logic [31:0]             read_data,
  input  logic [NPORTS*WIDTH-1:0] gpio_i,
  output logic [NPORTS*WIDTH-1:0] gpio_o,
  output logic                    irq
);
  localparam int IW = ADDR_W - 4;
  logic [IW-1:0] idx;
  reg_off_e off;
  logic hit, wr, unused_bits;
  logic [WIDTH-1:0] wd, rd;
  logic [NPORTS-1:0][WIDTH-1:0] dout, stat, mask, sync_v, rise;
  assign idx         = addr_bus[ADDR_W-1:4];
  assign off         = reg_off_e'({addr_bus[3:2], 2'b00});
  assign hit         = 32'(idx) < NPORTS;
  assign wr          = sel & write_sig & hit;
  assign wd          = write_data[WIDTH-1:0];
  assign unused_bits = ^{write_data, addr_bus[1:0]};
  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    rv32e_gpio_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .reset(reset),
      .d    (gpio_i[p*WIDTH +: WIDTH]),
      .q    (sync_v[p]),
      .rise (rise[p])
    );
  end
  always_ff @(posedge clk)
    if (reset) begin
      dout <= '0;
      stat <= '0;
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        if (wr && 32'(idx) == i && off == OFF_DOUT) dout[i] <= wd;
        stat[i] <= ((wr && 32'(idx) == i && off == OFF_STAT) ? stat[i] & ~wd : stat[i]) | rise[i];
      end
    end
`ifdef RV32E_GPIO_IRQ_EN
  always_ff @(posedge clk)
    if (reset) begin
      mask <= '0;
      irq  <= 1'b0;
    end else begin
      for (int i = 0; i < NPORTS; i++)
        if (wr && 32'(idx) == i && off == OFF_MASK) mask[i] <= wd;
      irq <= |(stat & mask);
    end
`else
  assign mask = '0;
  assign irq  = 1'b0;
`endif
  always_comb begin
    rd = '0;
    for (int i = 0; i < NPORTS; i++)
      if (32'(idx) == i)
        rd = off == OFF_DOUT ? dout[i] :
             off == OFF_DIN  ? sync_v[i] :
             off == OFF_STAT ? stat[i] : mask[i];
  end
  assign read_data = 32'(rd);
  assign gpio_o    = dout;
endmodule

// File: tb/tb_rv32e_mmio_gpio.sv
// tb_rv32e_mmio_gpio: randomized and directed self-checking bench against a delay-line reference model
module tb_rv32e_mmio_gpio;
  localparam int NP = 4;
  localparam int W  = 8;
  localparam int S  = 2;
`ifdef RV32E_GPIO_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sel = 1'b0;
  logic [7:0] addr_bus = '0;
  logic [31:0] write_data = '0;
  logic write_sig = 1'b0;
  logic [31:0] read_data;
  logic [31:0] gpio_i = '0;
  logic [31:0] gpio_o;
  logic irq;
  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] m_dout [NP];
  logic [7:0] m_stat [NP];
  logic [7:0] m_mask [NP];
  logic m_irq;
  logic [31:0] hist [$];
  rv32e_mmio_gpio #(.NPORTS(NP), .WIDTH(W), .ADDR_W(8), .SYNC_STAGES(S)) dut (
    .clk       (clk),
    .reset     (reset),
    .sel       (sel),
    .addr_bus  (addr_bus),
    .write_data(write_data),
    .write_sig (write_sig),
    .read_data (read_data),
    .gpio_i    (gpio_i),
    .gpio_o    (gpio_o),
    .irq       (irq)
  );
  always #5 clk = ~clk;
  task automatic m_clear();
    for (int p = 0; p < NP; p++) begin
      m_dout[p] = '0;
      m_stat[p] = '0;
      m_mask[p] = '0;
    end
    m_irq = 1'b0;
    hist.delete();
    for (int i = 0; i <= S; i++) hist.push_back('0);
  endtask
  function automatic logic [31:0] m_read(input logic [7:0] a);
    int p = int'(a[7:4]);
    if (p >= NP) return '0;
    case (a[3:2])
      2'd0:    return {24'h0, m_dout[p]};
      2'd1:    return {24'h0, hist[S-1][p*W +: W]};
      2'd2:    return {24'h0, m_stat[p]};
      default: return IRQ ? {24'h0, m_mask[p]} : '0;
    endcase
  endfunction
  function automatic logic [31:0] m_gpio_o();
    return {m_dout[3], m_dout[2], m_dout[1], m_dout[0]};
  endfunction
  task automatic step(input bit r, input bit s, input bit we, input logic [7:0] a,
                      input logic [31:0] wd, input logic [31:0] gi);
    logic [7:0] nd [NP];
    logic [7:0] ns [NP];
    logic [7:0] nm [NP];
    logic [7:0] rise;
    logic ni;
    bit hit;
    reset = r; sel = s; write_sig = we; addr_bus = a; write_data = wd; gpio_i = gi;
    ni = 1'b0;
    for (int p = 0; p < NP; p++) begin
      hit   = s && we && int'(a[7:4]) == p;
      rise  = hist[S-1][p*W +: W] & ~hist[S][p*W +: W];
      nd[p] = (hit && a[3:2] == 2'd0) ? wd[7:0] : m_dout[p];
      ns[p] = ((hit && a[3:2] == 2'd2) ? m_stat[p] & ~wd[7:0] : m_stat[p]) | rise;
      nm[p] = (IRQ && hit && a[3:2] == 2'd3) ? wd[7:0] : m_mask[p];
      ni    = ni | (IRQ && |(m_stat[p] & m_mask[p]));
    end
    @(posedge clk);
    #1;
    if (r) m_clear();
    else begin
      for (int p = 0; p < NP; p++) begin
        m_dout[p] = nd[p];
        m_stat[p] = ns[p];
        m_mask[p] = nm[p];
      end
      m_irq = ni;
      hist.push_front(gi);
      void'(hist.pop_back());
    end
  endtask
  task automatic peek(input logic [7:0] a);
    sel = 1'b1; write_sig = 1'b0; addr_bus = a;
    #1;
  endtask
  task automatic test_reset();
    step(1, 1, 1, 8'h00, 32'hFF, 32'hFFFF_FFFF);
    step(1, 1, 1, 8'h10, 32'hFF, 32'hFFFF_FFFF);
    n_chk++; if (gpio_o !== 32'h0) $display("FAIL reset_gpio_o got %h want 0", gpio_o); else n_pass++;
    n_chk++; if (irq !== 1'b0) $display("FAIL reset_irq got %b want 0", irq); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 0, 8'h00, 32'h0, 32'hFFFF_FFFF);
      peek(8'(i * 4));
      n_chk++;
      if (read_data !== 32'h0) $display("FAIL reset_read addr %h got %h want 0", i * 4, read_data);
      else n_pass++;
    end
    step(0, 0, 0, 8'h00, 32'h0, 32'hFFFF_FFFF);
    step(0, 0, 0, 8'h00, 32'h0, 32'hFFFF_FFFF);
    peek(8'h34);
    n_chk++; if (read_data !== 32'hFF) $display("FAIL reset_din got %h want ff", read_data); else n_pass++;
    peek(8'h08);
    n_chk++; if (read_data !== 32'h0) $display("FAIL reset_stat got %h want 0", read_data); else n_pass++;
    for (int i = 0; i < 4; i++) step(0, 0, 0, 8'h00, 32'h0, 32'h0);
    for (int p = 0; p < NP; p++) step(0, 1, 1, 8'(p * 16 + 8), 32'hFF, 32'h0);
    for (int p = 0; p < NP; p++) begin
      peek(8'(p * 16 + 8));
      n_chk++;
      if (read_data !== 32'h0) $display("FAIL reset_clear port %0d got %h want 0", p, read_data);
      else n_pass++;
    end
  endtask
  task automatic test_dout();
    step(0, 1, 1, 8'h10, 32'hA5, 32'h0);
    n_chk++; if (gpio_o !== 32'h0000_A500) $display("FAIL dout_gpio_o got %h want 0000a500", gpio_o); else n_pass++;
    peek(8'h10);
    n_chk++; if (read_data !== 32'hA5) $display("FAIL dout_read got %h want a5", read_data); else n_pass++;
  endtask
  task automatic test_edge();
    step(0, 0, 0, 8'h00, 32'h0, 32'h81);
    peek(8'h04);
    n_chk++; if (read_data !== 32'h0) $display("FAIL edge_din_1clk got %h want 0", read_data); else n_pass++;
    step(0, 0, 0, 8'h00, 32'h0, 32'h81);
    peek(8'h04);
    n_chk++; if (read_data !== 32'h81) $display("FAIL edge_din_2clk got %h want 81", read_data); else n_pass++;
    peek(8'h08);
    n_chk++; if (read_data !== 32'h0) $display("FAIL edge_stat_2clk got %h want 0", read_data); else n_pass++;
    step(0, 0, 0, 8'h00, 32'h0, 32'h81);
    peek(8'h08);
    n_chk++; if (read_data !== 32'h81) $display("FAIL edge_stat_3clk got %h want 81", read_data); else n_pass++;
  endtask
  task automatic test_set_wins();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00, 32'h0, 32'h80);
    step(0, 0, 0, 8'h00, 32'h0, 32'h81);
    step(0, 0, 0, 8'h00, 32'h0, 32'h81);
    step(0, 1, 1, 8'h08, 32'h01, 32'h81);
    peek(8'h08);
    n_chk++; if (read_data !== 32'h81) $display("FAIL setwins_stat got %h want 81", read_data); else n_pass++;
    step(0, 1, 1, 8'h08, 32'h80, 32'h81);
    peek(8'h08);
    n_chk++; if (read_data !== 32'h01) $display("FAIL w1c_bit7 got %h want 01", read_data); else n_pass++;
    step(0, 1, 1, 8'h08, 32'h01, 32'h81);
    peek(8'h08);
    n_chk++; if (read_data !== 32'h00) $display("FAIL w1c_bit0 got %h want 00", read_data); else n_pass++;
  endtask
  task automatic test_irq();
    step(0, 1, 1, 8'h2C, 32'h02, 32'h81);
    peek(8'h2C);
    n_chk++;
    if (read_data !== (IRQ ? 32'h02 : 32'h0)) $display("FAIL irq_mask_read got %h want %h", read_data, IRQ ? 32'h02 : 32'h0);
    else n_pass++;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00, 32'h0, 32'h0002_0081);
    peek(8'h28);
    n_chk++; if (read_data !== 32'h02) $display("FAIL irq_stat got %h want 02", read_data); else n_pass++;
    n_chk++; if (irq !== 1'b0) $display("FAIL irq_early got %b want 0", irq); else n_pass++;
    step(0, 0, 0, 8'h00, 32'h0, 32'h0002_0081);
    n_chk++; if (irq !== IRQ) $display("FAIL irq_assert got %b want %b", irq, IRQ); else n_pass++;
    step(0, 1, 1, 8'h28, 32'h02, 32'h0002_0081);
    step(0, 0, 0, 8'h00, 32'h0, 32'h0002_0081);
    n_chk++; if (irq !== 1'b0) $display("FAIL irq_clear got %b want 0", irq); else n_pass++;
  endtask
  task automatic test_range();
    step(0, 1, 1, 8'h40, 32'hFF, 32'h81);
    n_chk++; if (gpio_o !== 32'h0000_A500) $display("FAIL range_gpio_o got %h want 0000a500", gpio_o); else n_pass++;
    peek(8'h44);
    n_chk++; if (read_data !== 32'h0) $display("FAIL range_read44 got %h want 0", read_data); else n_pass++;
    peek(8'hF8);
    n_chk++; if (read_data !== 32'h0) $display("FAIL range_readf8 got %h want 0", read_data); else n_pass++;
    step(0, 0, 1, 8'h10, 32'h11, 32'h81);
    n_chk++; if (gpio_o !== 32'h0000_A500) $display("FAIL nosel_gpio_o got %h want 0000a500", gpio_o); else n_pass++;
    step(0, 1, 1, 8'h04, 32'h55, 32'h81);
    peek(8'h04);
    n_chk++; if (read_data !== 32'h81) $display("FAIL din_write got %h want 81", read_data); else n_pass++;
    step(0, 1, 1, 8'h13, 32'hFFFF_FF3C, 32'h81);
    n_chk++; if (gpio_o !== 32'h0000_3C00) $display("FAIL lowbits_gpio_o got %h want 00003c00", gpio_o); else n_pass++;
    peek(8'h10);
    n_chk++; if (read_data !== 32'h3C) $display("FAIL upper_zero got %h want 3c", read_data); else n_pass++;
  endtask
  task automatic test_random();
    logic [31:0] gi = 32'h81;
    logic [7:0] a;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) gi = $urandom;
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           8'($urandom_range(0, 95)), $urandom, gi);
      n_chk++;
      if (gpio_o !== m_gpio_o()) $display("FAIL rnd_gpio_o cyc %0d got %h want %h", i, gpio_o, m_gpio_o());
      else n_pass++;
      n_chk++;
      if (irq !== m_irq) $display("FAIL rnd_irq cyc %0d got %b want %b", i, irq, m_irq);
      else n_pass++;
      a = 8'($urandom_range(0, 95));
      peek(a);
      n_chk++;
      if (read_data !== m_read(a)) $display("FAIL rnd_read cyc %0d addr %h got %h want %h", i, a, read_data, m_read(a));
      else n_pass++;
    end
  endtask
  initial begin
    m_clear();
    test_reset();
    test_dout();
    test_edge();
    test_set_wins();
    test_irq();
    test_range();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
